// File: rtl/ov7670_frame_capture_if.sv
// Camera pin bundle plus frame-buffer write port of the OV7670 capture block.
interface ov7670_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        data;
  logic [11:0]       rgb;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  modport master (output vsync, href, data, input rgb, wr_addr, wr_en);
  modport slave  (input vsync, href, data, output rgb, wr_addr, wr_en);
endinterface

// File: rtl/ov7670_frame_capture.sv
// OV7670 byte-pair deserialiser: assembles RGB444 pixels and linear frame-buffer
// write addresses, with frame/line status and error reporting.
module ov7670_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                   pclk_i,
  input  logic                   rst_i,
  input  logic [1:0]             mode_i,
  ov7670_frame_capture_if.slave  cam_if,
  output logic                   frame_start_o,
  output logic                   frame_done_o,
  output logic                   line_err_o,
  output logic                   frame_err_o,
  output logic                   err_sticky_o,
  output logic [15:0]            frame_cnt_o
);
  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  H_LAST = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0]  V_LAST = ROW_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [2:0] {S_SYNC, S_VBLANK, S_LINE_WAIT, S_CAPTURE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               phase_q, phase_d, excess_q, excess_d;
  logic [7:0]         byte1_q, byte1_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d, row_inc;
  logic [ADDR_W-1:0]  base_q, base_d, wr_addr_q, wr_addr_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               wr_en_q, wr_en_d, fstart_q, fstart_d, fdone_q, fdone_d;
  logic               lerr_q, lerr_d, ferr_q, ferr_d, sticky_q, sticky_d;
  logic [15:0]        fcnt_q, fcnt_d;

  function automatic logic [11:0] conv_pix(input logic [1:0] m, input logic [7:0] b1,
                                           input logic [7:0] b2);
    logic [11:0] px;
    case (m)
      2'd1:    px = {b1[7:4], b1[2:0], b2[7], b2[4:1]};
      2'd2:    px = {b1[7:4], b1[7:4], b1[7:4]};
      default: px = {b1[3:0], b2[7:4], b2[3:0]};
    endcase
    return px;
  endfunction

  assign row_inc = row_q + ROW_W'(1);

  // State and datapath register bank
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q   <= S_SYNC;
      mode_q    <= 2'd0;
      phase_q   <= 1'b0;
      excess_q  <= 1'b0;
      byte1_q   <= 8'd0;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      wr_addr_q <= '0;
      rgb_q     <= 12'd0;
      wr_en_q   <= 1'b0;
      fstart_q  <= 1'b0;
      fdone_q   <= 1'b0;
      lerr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      sticky_q  <= 1'b0;
      fcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      excess_q  <= excess_d;
      byte1_q   <= byte1_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      rgb_q     <= rgb_d;
      wr_en_q   <= wr_en_d;
      fstart_q  <= fstart_d;
      fdone_q   <= fdone_d;
      lerr_q    <= lerr_d;
      ferr_q    <= ferr_d;
      sticky_q  <= sticky_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // Next-state and pulse generation
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    phase_d   = phase_q;
    excess_d  = excess_q;
    byte1_d   = byte1_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    rgb_d     = rgb_q;
    wr_en_d   = 1'b0;
    fstart_d  = 1'b0;
    fdone_d   = 1'b0;
    lerr_d    = 1'b0;
    ferr_d    = 1'b0;
    fcnt_d    = fcnt_q;
    case (state_q)
      S_SYNC: begin
        if (cam_if.vsync) state_d = S_VBLANK;
        else              state_d = S_SYNC;
      end
      S_VBLANK: begin
        if (!cam_if.vsync) begin
          state_d  = S_LINE_WAIT;
          row_d    = '0;
          base_d   = '0;
          phase_d  = 1'b0;
          excess_d = 1'b0;
          mode_d   = (mode_i == 2'd3) ? 2'd0 : mode_i;
          fstart_d = 1'b1;
        end else begin
          state_d = S_VBLANK;
        end
      end
      S_LINE_WAIT: begin
        if (cam_if.vsync) begin
          state_d = S_VBLANK;
          ferr_d  = (row_q < V_LAST);
        end else if (cam_if.href) begin
          state_d  = S_CAPTURE;
          col_d    = '0;
          byte1_d  = cam_if.data;
          phase_d  = 1'b1;
          excess_d = 1'b0;
        end else begin
          state_d = S_LINE_WAIT;
        end
      end
      S_CAPTURE: begin
        if (cam_if.vsync) begin
          state_d = S_VBLANK;
          ferr_d  = (row_q < V_LAST);
        end else if (cam_if.href) begin
          if (!phase_q) begin
            byte1_d = cam_if.data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < H_LAST) begin
              wr_en_d   = 1'b1;
              rgb_d     = conv_pix(mode_q, byte1_q, cam_if.data);
              wr_addr_d = base_q + ADDR_W'(col_q);
              col_d     = col_q + COL_W'(1);
            end else begin
              excess_d = 1'b1;
            end
          end
        end else begin
          // Base advances by a full line even on short lines to keep rows aligned
          lerr_d   = (col_q != H_LAST) | phase_q | excess_q;
          row_d    = row_inc;
          base_d   = base_q + H_STEP;
          phase_d  = 1'b0;
          excess_d = 1'b0;
          if (row_inc == V_LAST) begin
            fdone_d = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = S_DONE;
          end else begin
            state_d = S_LINE_WAIT;
          end
        end
      end
      S_DONE: begin
        if (cam_if.vsync) state_d = S_VBLANK;
        else              state_d = S_DONE;
      end
      default: state_d = S_SYNC;
    endcase
    sticky_d = sticky_q | lerr_d | ferr_d;
  end

  assign cam_if.rgb     = rgb_q;
  assign cam_if.wr_addr = wr_addr_q;
  assign cam_if.wr_en   = wr_en_q;
  assign frame_start_o  = fstart_q;
  assign frame_done_o   = fdone_q;
  assign line_err_o     = lerr_q;
  assign frame_err_o    = ferr_q;
  assign err_sticky_o   = sticky_q;
  assign frame_cnt_o    = fcnt_q;
endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed self-checking bench for ov7670_frame_capture with a 4x3 frame.
module tb_ov7670_frame_capture;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        frame_start, frame_done, line_err, frame_err, err_sticky;
  logic [15:0] frame_cnt;

  ov7670_frame_capture_if #(.ADDR_W(AW)) cam_if ();

  ov7670_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk_i        (pclk),
    .rst_i         (rst),
    .mode_i        (mode),
    .cam_if        (cam_if.slave),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .line_err_o    (line_err),
    .frame_err_o   (frame_err),
    .err_sticky_o  (err_sticky),
    .frame_cnt_o   (frame_cnt)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0]   log_rgb  [64];
  logic [AW-1:0] log_addr [64];
  int wr_n = 0, fs_n = 0, fd_n = 0, le_n = 0, fe_n = 0, anom_n = 0;
  logic prev_we = 1'b0, prev_fs = 1'b0, prev_fd = 1'b0, prev_le = 1'b0, prev_fe = 1'b0;

  // Write log and pulse counters sampled mid-cycle
  always @(negedge pclk) begin
    if (cam_if.wr_en && wr_n < 64) begin
      log_rgb[wr_n]  <= cam_if.rgb;
      log_addr[wr_n] <= cam_if.wr_addr;
    end
    if (cam_if.wr_en) wr_n <= wr_n + 1;
    if (frame_start) fs_n <= fs_n + 1;
    if (frame_done)  fd_n <= fd_n + 1;
    if (line_err)    le_n <= le_n + 1;
    if (frame_err)   fe_n <= fe_n + 1;
    if ((cam_if.wr_en && prev_we) || (frame_start && prev_fs) || (frame_done && prev_fd) ||
        (line_err && prev_le) || (frame_err && prev_fe) || ((line_err || frame_err) && !err_sticky))
      anom_n <= anom_n + 1;
    prev_we <= cam_if.wr_en;
    prev_fs <= frame_start;
    prev_fd <= frame_done;
    prev_le <= line_err;
    prev_fe <= frame_err;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2, input logic exp_wr);
    cam_if.href = 1'b1;
    cam_if.data = b1;
    tick();
    check_val("wr_en_after_b1", 32'(cam_if.wr_en), 32'd0);
    cam_if.data = b2;
    tick();
    check_val("wr_en_after_b2", 32'(cam_if.wr_en), 32'(exp_wr));
  endtask

  task automatic end_line();
    cam_if.href = 1'b0;
    cam_if.data = 8'd0;
    tick();
    tick();
  endtask

  task automatic frame_gap(input logic [1:0] m);
    mode = m;
    cam_if.vsync = 1'b1;
    tick();
    tick();
    cam_if.vsync = 1'b0;
    tick();
    tick();
  endtask

  logic [7:0]  kk;
  logic [3:0]  ea;
  logic [7:0]  eb;
  logic [11:0] exp3 [7];
  logic [AW-1:0] expa3 [7];
  int base_i;

  initial begin
    cam_if.vsync = 1'b0;
    cam_if.href  = 1'b0;
    cam_if.data  = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_val("rst_wr_en",  32'(cam_if.wr_en),   32'd0);
    check_val("rst_rgb",    32'(cam_if.rgb),     32'd0);
    check_val("rst_addr",   32'(cam_if.wr_addr), 32'd0);
    check_val("rst_fcnt",   32'(frame_cnt),      32'd0);
    check_val("rst_sticky", 32'(err_sticky),     32'd0);

    // Lines before any vsync cycle must be ignored
    send_pixel(8'h0A, 8'hBC, 1'b0);
    send_pixel(8'h12, 8'h34, 1'b0);
    end_line();
    check_val("nosync_writes", 32'(wr_n), 32'd0);
    check_val("nosync_fs",     32'(fs_n), 32'd0);

    // Full RGB444 frame
    frame_gap(2'd0);
    check_val("f1_start", 32'(fs_n), 32'd1);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        kk = 8'(r * H + c);
        send_pixel({4'h0, 4'hA ^ kk[3:0]}, 8'hBC + kk, 1'b1);
      end
      end_line();
    end
    check_val("f1_writes", 32'(wr_n), 32'd12);
    for (int k = 0; k < 12; k++) begin
      kk = 8'(k);
      ea = 4'hA ^ kk[3:0];
      eb = 8'hBC + kk;
      check_val("f1_addr", 32'(log_addr[k]), 32'(k));
      check_val("f1_rgb",  32'(log_rgb[k]),  32'({ea, eb}));
    end
    check_val("f1_done",   32'(fd_n),       32'd1);
    check_val("f1_fcnt",   32'(frame_cnt),  32'd1);
    check_val("f1_lerr",   32'(le_n),       32'd0);
    check_val("f1_sticky", 32'(err_sticky), 32'd0);

    // RGB565 frame, mode changed mid-frame, aborted after one line
    frame_gap(2'd1);
    base_i = wr_n;
    send_pixel(8'hF8, 8'h1F, 1'b1);
    send_pixel(8'h07, 8'hE0, 1'b1);
    mode = 2'd2;
    send_pixel(8'h9A, 8'h55, 1'b1);
    send_pixel(8'h00, 8'h00, 1'b1);
    end_line();
    check_val("f2_rgb0",  32'(log_rgb[base_i]),      32'h0F0F);
    check_val("f2_rgb1",  32'(log_rgb[base_i + 1]),  32'h00F0);
    check_val("f2_rgb2",  32'(log_rgb[base_i + 2]),  32'h094A);
    check_val("f2_addr3", 32'(log_addr[base_i + 3]), 32'd3);
    frame_gap(2'd2);
    check_val("f2_ferr",   32'(fe_n),       32'd1);
    check_val("f2_nodone", 32'(fd_n),       32'd1);
    check_val("f2_fcnt",   32'(frame_cnt),  32'd1);
    check_val("f2_sticky", 32'(err_sticky), 32'd1);
    check_val("f3_start",  32'(fs_n),       32'd3);

    // Grey frame: short line then long line
    base_i = wr_n;
    send_pixel(8'h9A, 8'h55, 1'b1);
    send_pixel(8'h30, 8'hFF, 1'b1);
    send_pixel(8'hC0, 8'h00, 1'b1);
    end_line();
    check_val("f3_lerr_short", 32'(le_n), 32'd1);
    send_pixel(8'h10, 8'h00, 1'b1);
    send_pixel(8'h20, 8'h00, 1'b1);
    send_pixel(8'h40, 8'h00, 1'b1);
    send_pixel(8'h70, 8'h00, 1'b1);
    send_pixel(8'hE0, 8'h00, 1'b0);
    end_line();
    check_val("f3_lerr_long", 32'(le_n),        32'd2);
    check_val("f3_writes",    32'(wr_n - base_i), 32'd7);
    exp3  = '{12'h999, 12'h333, 12'hCCC, 12'h111, 12'h222, 12'h444, 12'h777};
    expa3 = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int k = 0; k < 7; k++) begin
      check_val("f3_rgb",  32'(log_rgb[base_i + k]),  32'(exp3[k]));
      check_val("f3_addr", 32'(log_addr[base_i + k]), 32'(expa3[k]));
    end
    check_val("f3_sticky", 32'(err_sticky), 32'd1);

    // Reset in the middle of a line
    send_pixel(8'h55, 8'h66, 1'b1);
    check_val("f3_row2_addr", 32'(cam_if.wr_addr), 32'd8);
    cam_if.data = 8'h77;
    tick();
    rst = 1'b1;
    cam_if.data = 8'h88;
    tick();
    rst = 1'b0;
    check_val("mid_rst_wr_en",  32'(cam_if.wr_en), 32'd0);
    check_val("mid_rst_fcnt",   32'(frame_cnt),    32'd0);
    check_val("mid_rst_sticky", 32'(err_sticky),   32'd0);
    base_i = wr_n;
    send_pixel(8'h11, 8'h22, 1'b0);
    send_pixel(8'h33, 8'h44, 1'b0);
    end_line();
    check_val("post_rst_writes", 32'(wr_n - base_i), 32'd0);
    frame_gap(2'd0);
    check_val("post_rst_start", 32'(fs_n), 32'd4);
    base_i = wr_n;
    send_pixel(8'h0A, 8'hBC, 1'b1);
    end_line();
    check_val("post_rst_addr", 32'(log_addr[base_i]), 32'd0);
    check_val("post_rst_rgb",  32'(log_rgb[base_i]),  32'h0ABC);
    check_val("pulse_shape",   32'(anom_n),           32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
